race_puf_sequencer: RTL

Sequencer for the serial race-arbiter PUF. It takes one challenge request and runs RESP_BITS races back to back. For each race it drives the race path's reset/enable and a per-race challenge word, synchronises the arbiter's asynchronous `done`/`out`, and shifts the winner bit into a response register. It sits between the host-side control logic and the race datapath (delay paths/counters plus race arbiter).

---
 rtl/race_puf_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/race_puf_sequencer.sv
// race_puf_sequencer
// Sequencer for a serial race-arbiter PUF. One accepted start request runs
// RESP_BITS races back to back. For each race it:
//   - drives the race path's reset/enable and a per-race challenge word,
//   - synchronises the arbiter's done/out,
//   - shifts the winner bit into the response register (race 0 ends in the MSB).
//
// Optional build macro: RACE_MAJORITY_EN
//   Each bit is raced three times with the same challenge word, and the
//   recorded bit is the majority of the three samples. When the macro is
//   undefined, each bit is a single race and no vote logic exists.
//
// Ports:
//   clk            - single clock, rising edge
//   reset_n        - asynchronous active-low reset
//   start          - request pulse, accepted only in IDLE
//   challenge_base - base challenge, latched when start is accepted
//   arb_done       - arbiter done (asynchronous to clk)
//   arb_out        - arbiter out  (asynchronous to clk)
//   race_reset     - active-high reset to race path and arbiter
//   race_en        - race launch enable
//   chal_out       - challenge word for the current race (base + idx, wraps)
//   busy           - high in every state except IDLE
//   resp_valid     - one-cycle pulse with the completed response
//   response       - collected response, held until next accepted start
//   timeout_err    - sticky: some race timed out in this request
module race_puf_sequencer #(
  parameter int RESP_BITS = 32,
  parameter int CHAL_W    = 8,
  parameter int SETTLE    = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    challenge_base,
  input  logic                 arb_done,
  input  logic                 arb_out,
  output logic                 race_reset,
  output logic                 race_en,
  output logic [CHAL_W-1:0]    chal_out,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] response,
  output logic                 timeout_err
);

  localparam int IDX_W   = $clog2(RESP_BITS);
  localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RACE    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CHAL_W-1:0] base_r;
  logic              tmo_r;     // current race was abandoned; capture records 0
  logic              done_meta_r;
  logic              done_s;
  logic              out_meta_r;
  logic              out_s;
  logic              cap_bit_s;
  logic              bit_s;
  logic              last_pass_s;
  logic [CHAL_W-1:0] chal_next_s;

  // Two-flop synchronisers for the asynchronous arbiter outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_meta_r <= 1'b0;
      done_s      <= 1'b0;
      out_meta_r  <= 1'b0;
      out_s       <= 1'b0;
    end else begin
      done_meta_r <= arb_done;
      done_s      <= done_meta_r;
      out_meta_r  <= arb_out;
      out_s       <= out_meta_r;
    end
  end

  // A timed-out race never samples out_s.
  assign cap_bit_s   = tmo_r ? 1'b0 : out_s;
  assign chal_next_s = base_r + CHAL_W'(idx_r + IDX_W'(1));

`ifdef RACE_MAJORITY_EN
  logic [1:0] votes_r;   // ones seen in earlier passes of this bit
  logic [1:0] pass_r;    // pass number 0..2 of this bit
  assign bit_s       = ((votes_r + {1'b0, cap_bit_s}) >= 2'd2);
  assign last_pass_s = (pass_r == 2'd2);
`else
  assign bit_s       = cap_bit_s;
  assign last_pass_s = 1'b1;
`endif

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      cnt_r       <= '0;
      base_r      <= '0;
      tmo_r       <= 1'b0;
      race_reset  <= 1'b1;
      race_en     <= 1'b0;
      chal_out    <= '0;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      response    <= '0;
      timeout_err <= 1'b0;
`ifdef RACE_MAJORITY_EN
      votes_r     <= 2'd0;
      pass_r      <= 2'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          race_reset <= 1'b1;
          race_en    <= 1'b0;
          resp_valid <= 1'b0;
          if (start) begin
            base_r      <= challenge_base;
            chal_out    <= challenge_base;
            idx_r       <= '0;
            cnt_r       <= '0;
            tmo_r       <= 1'b0;
            response    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state_r     <= ST_CLEAR;
`ifdef RACE_MAJORITY_EN
            votes_r     <= 2'd0;
            pass_r      <= 2'd0;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (cnt_r == CNT_W'(SETTLE - 1)) begin
            cnt_r      <= '0;
            race_reset <= 1'b0;
            race_en    <= 1'b1;
            state_r    <= ST_RACE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RACE: begin
          // A done already present on entry is accepted as a real done.
          if (done_s) begin
            race_en <= 1'b0;
            state_r <= ST_CAPTURE;
          end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            race_en     <= 1'b0;
            tmo_r       <= 1'b1;
            timeout_err <= 1'b1;
            state_r     <= ST_CAPTURE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          // The arbiter is not reset here, so out has had one extra cycle to settle.
          cnt_r      <= '0;
          tmo_r      <= 1'b0;
          race_reset <= 1'b1;
          if (!last_pass_s) begin
`ifdef RACE_MAJORITY_EN
            votes_r <= votes_r + {1'b0, cap_bit_s};
            pass_r  <= pass_r + 2'd1;
`endif
            state_r <= ST_CLEAR;
          end else begin
            response <= {response[RESP_BITS-2:0], bit_s};
`ifdef RACE_MAJORITY_EN
            votes_r  <= 2'd0;
            pass_r   <= 2'd0;
`endif
            if (idx_r == IDX_W'(RESP_BITS - 1)) begin
              resp_valid <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              idx_r    <= idx_r + IDX_W'(1);
              chal_out <= chal_next_s;
              state_r  <= ST_CLEAR;
            end
          end
        end
        ST_DONE: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          race_reset <= 1'b1;
          race_en    <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
          race_reset <= 1'b1;
          race_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule
